// File: rtl/btn_pkg.sv
// Shared types, defaults and sizing helper for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    DOWN,
    REL_CHK
  } btn_state_t;

  localparam int unsigned DEF_NBTN            = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the raw inputs and the conditioned press/release/level outputs.
interface btn_conditioner_if
  import btn_pkg::*;
#(
  parameter int unsigned NBTN = DEF_NBTN
);
  logic [NBTN-1:0] btn;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic            btn_any;

  modport master (output btn, input btn_level, btn_press, btn_release, btn_any);
  modport slave  (input btn, output btn_level, btn_press, btn_release, btn_any);
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and counter.
// Auto-repeat counter present only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  if ((DEBOUNCE_CYCLES == 0) || (REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_param_err
    $error("btn_debounce_ch: cycle parameters must be >= 1");
  end

  logic          s1, s2;
  btn_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          press_deb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_deb = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_n = PRESS_CHK;
          cnt_n   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s2) begin
          state_n = IDLE;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_n   = DOWN;
          press_deb = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      DOWN: begin
        if (!s2) begin
          state_n = REL_CHK;
          cnt_n   = '0;
        end
      end
      REL_CHK: begin
        if (s2) begin
          state_n = DOWN;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_n = IDLE;
          rel     = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Level follows the next state so the top's single output register lines it up with the pulses.
  assign level = (state_n == DOWN) || (state_n == REL_CHK);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = cnt_width(RMAX);

  logic [RW-1:0] rcnt, rcnt_n;
  logic          rphase, rphase_n;
  logic          press_rep;

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else begin
      rcnt   <= rcnt_n;
      rphase <= rphase_n;
    end
  end

  // Clears only on a fresh press; REL_CHK leaves it untouched so a bounce resumes the schedule.
  always_comb begin
    rcnt_n    = rcnt;
    rphase_n  = rphase;
    press_rep = 1'b0;
    if ((state == PRESS_CHK) && (state_n == DOWN)) begin
      rcnt_n   = '0;
      rphase_n = 1'b0;
    end else if ((state == DOWN) && s2) begin
      if (!rphase && (rcnt == RW'(REPEAT_DELAY - 1))) begin
        press_rep = 1'b1;
        rphase_n  = 1'b1;
        rcnt_n    = '0;
      end else if (rphase && (rcnt == RW'(REPEAT_PERIOD - 1))) begin
        press_rep = 1'b1;
        rcnt_n    = '0;
      end else if (rcnt != '1) begin
        rcnt_n = rcnt + 1'b1;
      end
    end
  end

  assign press = press_deb | press_rep;
`else
  assign press = press_deb;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel debounce, highest-index press arbitration, registered outputs.
// Optional auto-repeat enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NBTN            = DEF_NBTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic               clk,
  input logic               rst,
  btn_conditioner_if.slave  bus
);
  logic [NBTN-1:0] level_n;
  logic [NBTN-1:0] press_raw;
  logic [NBTN-1:0] rel_raw;
  logic [NBTN-1:0] press_arb;

  for (genvar g = 0; g < NBTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.btn[g]),
      .level (level_n[g]),
      .press (press_raw[g]),
      .rel   (rel_raw[g])
    );
  end

  // Highest index wins; lower simultaneous presses are dropped.
  always_comb begin
    press_arb = '0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (press_raw[i]) begin
        press_arb    = '0;
        press_arb[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.btn_level   <= '0;
      bus.btn_press   <= '0;
      bus.btn_release <= '0;
      bus.btn_any     <= 1'b0;
    end else begin
      bus.btn_level   <= level_n;
      bus.btn_press   <= press_arb;
      bus.btn_release <= rel_raw;
      bus.btn_any     <= |level_n;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and randomized checks of btn_conditioner against a run-length reference model.
module tb_btn_conditioner;
  localparam int unsigned NB = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btn_conditioner_if #(.NBTN(NB)) bus ();

  btn_conditioner #(
    .NBTN            (NB),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a level flips after D+1 consecutive sampled edges disagreeing with it.
  logic [NB-1:0] m_sh1 = '0, m_sh2 = '0, m_lvl = '0, m_press = '0, m_rel = '0;
  int run  [NB];
  int dcnt [NB];

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [NB-1:0] rawp, relp;
    @(posedge clk);
    rawp = '0;
    relp = '0;
    if (rst) begin
      m_sh1 = '0;
      m_sh2 = '0;
      m_lvl = '0;
      for (int i = 0; i < NB; i++) begin
        run[i]  = 0;
        dcnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (m_sh2[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            m_lvl[i] = m_sh2[i];
            run[i]   = 0;
            if (m_sh2[i]) begin
              rawp[i] = 1'b1;
              dcnt[i] = 0;
            end else begin
              relp[i] = 1'b1;
            end
          end
        end else begin
          if (m_lvl[i] && run[i] == 0) begin
            dcnt[i]++;
`ifdef BTN_AUTOREPEAT_EN
            if (dcnt[i] >= RD && ((dcnt[i] - RD) % RP) == 0) rawp[i] = 1'b1;
`endif
          end
          run[i] = 0;
        end
      end
      m_sh2 = m_sh1;
      m_sh1 = bus.btn;
    end
    m_press = '0;
    for (int i = 0; i < NB; i++) if (rawp[i]) m_press = NB'(1) << i;
    m_rel = relp;
    #1;
    chk("level",   bus.btn_level,   m_lvl);
    chk("press",   bus.btn_press,   m_press);
    chk("release", bus.btn_release, m_rel);
    chk("any",     NB'(bus.btn_any), NB'(|m_lvl));
  endtask

  initial begin
    int p0, p1, r0, n;
    bus.btn = '0;
    for (int i = 0; i < NB; i++) begin
      run[i]  = 0;
      dcnt[i] = 0;
    end

    // Reset state
    repeat (3) tick();
    chk("reset_level", bus.btn_level, '0);
    chk("reset_press", bus.btn_press, '0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean press on channel 0: pulse after edge 7
    bus.btn = 2'b01;
    p0 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 6) chk("clean_press_early", bus.btn_press, 2'b00);
      if (k == 7) chk("clean_press_edge7", bus.btn_press, 2'b01);
      if (bus.btn_press[0]) p0++;
    end
    chk("clean_press_once", NB'(p0), NB'(1));

    // Release channel 0
    bus.btn = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 7) chk("rel0_edge7", bus.btn_release, 2'b01);
    end

    // Bounce rejection
    p0 = 0; r0 = 0;
    for (int k = 0; k < 30; k++) begin
      bus.btn[0] = ((k / 2) % 2) == 0;
      tick();
      if (bus.btn_press != 0) p0++;
      if (bus.btn_release != 0 || bus.btn_level != 0) r0++;
    end
    bus.btn = 2'b00;
    repeat (10) begin
      tick();
      if (bus.btn_press != 0) p0++;
      if (bus.btn_release != 0 || bus.btn_level != 0) r0++;
    end
    chk("bounce_no_press", NB'(p0), '0);
    chk("bounce_no_rel_lvl", NB'(r0), '0);

    // Simultaneous press: bit 1 wins
    bus.btn = 2'b11;
    p0 = 0; p1 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 7) chk("simul_edge7", bus.btn_press, 2'b10);
      if (bus.btn_press[0]) p0++;
      if (bus.btn_press[1]) p1++;
    end
    chk("simul_bit0_none", NB'(p0), '0);
    chk("simul_bit1_once", NB'(p1), NB'(1));
    chk("simul_level", bus.btn_level, 2'b11);

    // Release channel 1, channel 0 stays held
    bus.btn = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk("rel1_early", bus.btn_level, 2'b11);
      if (k == 7) begin
        chk("rel1_pulse", bus.btn_release, 2'b10);
        chk("rel1_level", bus.btn_level, 2'b01);
      end
    end

    // Reset mid-hold
    rst = 1'b1;
    tick();
    chk("midrst_level", bus.btn_level, '0);
    rst = 1'b0;
    p0 = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (bus.btn_press[0]) p0++;
      if (k == 7) chk("midrst_press7", bus.btn_press, 2'b01);
    end
    chk("midrst_once", NB'(p0), NB'(1));
    bus.btn = 2'b00;
    repeat (12) tick();

    // Long hold: auto-repeat stream or a single press
    bus.btn = 2'b01;
    p0 = 0;
    repeat (50) begin
      tick();
      if (bus.btn_press[0]) p0++;
    end
`ifdef BTN_AUTOREPEAT_EN
    n = 5;
`else
    n = 1;
`endif
    chk("hold_press_count", NB'(p0), NB'(n));
    bus.btn = 2'b00;
    repeat (12) tick();

    // Randomized bouncing traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 7) == 0) bus.btn[i] = ~bus.btn[i];
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Synchronises, debounces and edge-detects the raw push-button inputs and delivers clean single-cycle press/release pulses to the switch-load/increment counter and display stage that consumes `btn`. It sits directly upstream of that counter. The counter therefore sees exactly one qualified event per physical press, instead of sampling bouncing levels. Optional auto-repeat turns a held button into a periodic press stream.

## Interface
Parameters:
- `NBTN`, 2: number of button channels.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable `clk` cycles required to accept a level change; must be ≥1.
- `REPEAT_DELAY`, 25000000: cycles in the held state before the first repeat pulse (auto-repeat build only).
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses (auto-repeat build only).

Ports:
- `clk`, input, 1: the single system clock. All logic is on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `btn`, input, NBTN: raw, asynchronous, bouncing button levels. Active-high.
- `btn_level`, output, NBTN: debounced level per channel.
- `btn_press`, output, NBTN: one-hot single-cycle press pulse, after arbitration.
- `btn_release`, output, NBTN: single-cycle release pulse per channel. Not arbitrated.
- `btn_any`, output, 1: OR of `btn_level`.

## Operation
- Each channel passes through a 2-flop synchroniser (`s1`→`s2`). `s2` is the only value the FSM observes.
- Per-channel FSM states:
  - IDLE: stable low.
  - PRESS_CHK: counting stable high.
  - DOWN: stable high.
  - REL_CHK: counting stable low.
- FSM transitions:
  - IDLE, `s2`=1 → PRESS_CHK, cnt←0.
  - PRESS_CHK, `s2`=0 → IDLE. This is a glitch: no pulse.
  - PRESS_CHK, `s2`=1 and cnt=DEBOUNCE_CYCLES-1 → DOWN, raw press pulse. Otherwise cnt++.
  - DOWN, `s2`=0 → REL_CHK, cnt←0.
  - REL_CHK, `s2`=1 → DOWN. No pulse.
  - REL_CHK, `s2`=0 and cnt=DEBOUNCE_CYCLES-1 → IDLE, release pulse. Otherwise cnt++.
- cnt width: $clog2(DEBOUNCE_CYCLES+1). cnt saturates and never wraps.
- `btn_level[i]` is 1 in DOWN and REL_CHK, and 0 in IDLE and PRESS_CHK.
- Arbitration: when more than one channel raises a raw press in the same cycle, only the highest index is forwarded to `btn_press`. The others are dropped, not queued. This gives load (bit 1) priority over increment (bit 0).
- Release pulses and levels are never masked.

## Timing
- Reset value of all outputs is 0.
- Reset clears all FSMs to IDLE, cnt to 0 and the synchroniser flops to 0.
- Press latency: raw `btn[i]` goes high before edge 1 and stays high.
  - `s2`=1 after edge 2.
  - PRESS_CHK entered at edge 3.
  - `btn_press[i]` and `btn_level[i]` are high in the cycle after edge DEBOUNCE_CYCLES+3.
  - `btn_press` is exactly 1 cycle wide.
- Release latency is symmetric: `btn_release[i]` pulses in the cycle after edge DEBOUNCE_CYCLES+3 counted from the raw fall. `btn_level[i]` falls in that same cycle.
- Outputs are registered. No combinational path runs from `btn` to any output.
- Reset mid-operation: state is lost at the next edge.
  - If a button is held through reset, it is re-debounced from IDLE.
  - That button produces one press DEBOUNCE_CYCLES+3 edges after the first edge with `rst`=0.
- Bounce shorter than DEBOUNCE_CYCLES stable cycles produces no pulse, in either direction.

## Configuration
- Macro: `BTN_AUTOREPEAT_EN`.
- When defined, each channel has a repeat counter that clears on entry to DOWN.
  - A raw press is emitted after REPEAT_DELAY cycles in DOWN, then every REPEAT_PERIOD cycles while the channel stays in DOWN.
  - The counter holds, without clearing, while in REL_CHK. If the channel returns to DOWN, repeating resumes on schedule.
  - Repeat pulses go through the same arbitration as initial presses.
- When not defined, the repeat logic is absent. A held button produces exactly one press.

## Structure
- Package `btn_pkg` holds:
  - the FSM state enum (IDLE, PRESS_CHK, DOWN, REL_CHK);
  - the default-value localparams;
  - the counter-width function.
- Sub-module `btn_debounce_ch` covers one channel: synchroniser, FSM, debounce counter and optional repeat counter. It outputs level, raw press and release.
- The top `btn_conditioner` instantiates NBTN channels plus the priority arbiter and the output registers.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=6, NBTN=2.
- Clean press: `btn`=01 from edge 1, held → `btn_press`=01 for exactly one cycle after edge 7, `btn_level`=01 thereafter.
- Bounce rejection: `btn[0]` toggles every 2 cycles for 30 cycles, then settles at 0 → `btn_press`, `btn_release` and `btn_level` all stay 0.
- Simultaneous press: `btn`=11 at the same edge → `btn_press`=10 once, bit 0 never pulses, `btn_level`=11.
- Release: after a clean press, drop `btn[1]` → `btn_release`=10 one cycle after fall+7 edges, `btn_level[1]`=0 in the same cycle.
- Reset mid-hold: assert `rst` for 1 cycle while `btn[0]` is held in DOWN → outputs 0 next cycle, then one press 7 edges after `rst` falls.
- Auto-repeat (macro on): hold `btn[0]` → press at edge 7, then at 20 cycles after DOWN entry, then every 6 cycles. With the macro off, only the edge-7 press occurs.
